// File: rtl/sequenciador_fases.sv
// Central phase sequencer: one phase counter plus Moore phase strobes,
// start/halt control, memory-wait stall and retired-instruction count.
module sequenciador_fases #(
  parameter int NUM_FASES    = 10,
  parameter int FASE_BUSCA   = 0,
  parameter int FASE_DECOD   = 2,
  parameter int FASE_EXEC    = 4,
  parameter int FASE_MEM     = 6,
  parameter int FASE_ESCRITA = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        parar,
  input  logic        mem_pronta,
  output logic [3:0]  fase,
  output logic        en_busca,
  output logic        en_decod,
  output logic        en_exec,
  output logic        en_mem,
  output logic        en_escrita,
  output logic        ciclo_fim,
  output logic        ocupado,
  output logic [31:0] num_instr
);

  localparam logic [3:0] F_BUSCA = 4'(FASE_BUSCA);
  localparam logic [3:0] F_DECOD = 4'(FASE_DECOD);
  localparam logic [3:0] F_EXEC  = 4'(FASE_EXEC);
  localparam logic [3:0] F_MEM   = 4'(FASE_MEM);
  localparam logic [3:0] F_ESCR  = 4'(FASE_ESCRITA);
  localparam logic [3:0] F_ULT   = 4'(NUM_FASES - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    RODANDO,
    ESPERA_MEM,
    PARADO
  } estado_t;

  estado_t estado;
  logic    halt_pend;
  logic    rodando;
  logic    espera;

  // State, phase counter, pending-halt flag and instruction counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      fase      <= '0;
      halt_pend <= 1'b0;
      num_instr <= '0;
    end else begin
      unique case (estado)
        OCIOSO, PARADO: begin
          if (iniciar) begin
            estado <= RODANDO;
            fase   <= '0;
          end
        end
        RODANDO: begin
          if (parar)
            halt_pend <= 1'b1;
          if (fase == F_MEM) begin
            if (mem_pronta)
              fase <= F_MEM + 4'd1;
            else
              estado <= ESPERA_MEM;
          end else if (fase == F_ULT) begin
            fase      <= '0;
            num_instr <= num_instr + 32'd1;
            if (halt_pend || parar) begin
              estado    <= PARADO;
              halt_pend <= 1'b0;
            end
          end else begin
            fase <= fase + 4'd1;
          end
        end
        ESPERA_MEM: begin
          if (parar)
            halt_pend <= 1'b1;
          if (mem_pronta) begin
            estado <= RODANDO;
            fase   <= F_MEM + 4'd1;
          end
        end
        default: begin
          estado <= OCIOSO;
          fase   <= '0;
        end
      endcase
    end
  end

  // Moore strobe decode from registered state and phase
  always_comb begin
    rodando    = (estado == RODANDO);
    espera     = (estado == ESPERA_MEM);
    ocupado    = rodando || espera;
    en_busca   = ocupado && (fase == F_BUSCA);
    en_decod   = ocupado && (fase == F_DECOD);
    en_exec    = ocupado && (fase == F_EXEC);
    en_mem     = espera || (ocupado && (fase == F_MEM));
    en_escrita = ocupado && (fase == F_ESCR);
    ciclo_fim  = rodando && (fase == F_ULT);
  end

endmodule

// File: doc/sequenciador_fases.md
# sequenciador_fases

Central phase sequencer for the multicycle datapath: one 10-phase counter and phase-enable strobes replace the private per-component `cont` counters. Each datapath component (PC mux, register file, ALU, memory, writeback) acts only in the cycle its strobe is high. The block adds start/halt control, a memory-wait stall in the memory phase, and a retired-instruction counter.

## Interface
- `NUM_FASES`, 10, phases per instruction; phase counter range 0..NUM_FASES-1.
- `FASE_BUSCA`, 0, fetch phase.
- `FASE_DECOD`, 2, decode / register-read phase.
- `FASE_EXEC`, 4, execute phase; PC/address mux select phase.
- `FASE_MEM`, 6, memory-access phase; the only phase that can stall.
- `FASE_ESCRITA`, 8, writeback phase.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start request; sampled only in OCIOSO or PARADO.
- `parar`  in  1  halt request; sampled in RODANDO / ESPERA_MEM.
- `mem_pronta`  in  1  memory ready; sampled only while the phase is FASE_MEM.
- `fase`  out  4  current phase number.
- `en_busca`, `en_decod`, `en_exec`, `en_mem`, `en_escrita`  out  1 each  phase strobes.
- `ciclo_fim`  out  1  high during the final phase (NUM_FASES-1) of an instruction.
- `ocupado`  out  1  high in RODANDO or ESPERA_MEM.
- `num_instr`  out  32  count of completed instructions.

## Operation
- States: OCIOSO, RODANDO, ESPERA_MEM, PARADO. State and `fase` are registered. The `halt_pend` flag and `num_instr` are registered.
- All strobes are Moore-decoded from the registered state and `fase`, so they are glitch-free within the cycle.
- `en_X` = ocupado && fase==FASE_X. `en_mem` is also high for every ESPERA_MEM cycle. `ciclo_fim` = RODANDO && fase==NUM_FASES-1.
- OCIOSO: `fase`=0, all strobes 0. When `iniciar`=1, go to RODANDO with `fase`=0.
- RODANDO, normal phases: `fase` increments each cycle. After NUM_FASES-1, `fase` wraps to 0 and `num_instr` increments on that edge.
- RODANDO, `fase`==FASE_MEM:
  - `mem_pronta`=1: advance to FASE_MEM+1.
  - `mem_pronta`=0: go to ESPERA_MEM with `fase` held.
- ESPERA_MEM: `fase` stays at FASE_MEM and `en_mem` stays high. When `mem_pronta`=1, return to RODANDO with `fase`=FASE_MEM+1.
- `parar`=1 in any RODANDO or ESPERA_MEM cycle sets `halt_pend`. The current instruction always completes.
  - At the wrap edge with `halt_pend`=1 (or `parar`=1 in that same cycle), still increment `num_instr`.
  - Then go to PARADO with `fase`=0 and clear `halt_pend`.
- PARADO: outputs as in OCIOSO, `num_instr` retained. When `iniciar`=1, go to RODANDO with `fase`=0.
- Ignored inputs:
  - `iniciar` while `ocupado`.
  - `parar` in OCIOSO or PARADO.
  - `mem_pronta` outside FASE_MEM.
- `num_instr` is a 32-bit unsigned counter. It wraps from 0xFFFFFFFF to 0 and is cleared only by reset.

## Timing
- Reset asserted (`reset`=0), taking effect immediately, independent of `clock`:
  - state=OCIOSO, `fase`=0, `halt_pend`=0, `num_instr`=0.
  - All strobes, `ciclo_fim` and `ocupado` are 0.
- Reset released: OCIOSO persists until `iniciar` is sampled high.
- `iniciar` sampled high at edge k: `ocupado` and `en_busca` are high in cycle k+1.
- No stalls: 10 cycles per instruction, strobes one cycle wide at phases 0, 2, 4, 6, 8. `ciclo_fim` is high in phase 9. `num_instr` updates at the edge ending phase 9.
- W cycles with `mem_pronta`=0 in the memory phase: instruction takes 10+W cycles, and `en_mem` is high for W+1 consecutive cycles.
- Reset mid-instruction (any state, any phase): immediate return to OCIOSO. No partial count is recorded.
- Back-to-back instructions: phase 9 is followed directly by phase 0 of the next instruction, with no bubble.

## Test plan
- Reset and start: assert `reset`=0, release it, then pulse `iniciar` for 1 cycle. Required: `fase` steps 0..9, `en_busca` in cycle 1, `en_exec` in cycle 5, `ciclo_fim` in cycle 10, then `num_instr`=1.
- Free run: run 3 instructions with `mem_pronta`=1. Required: exactly 30 cycles, `num_instr`=3, and each strobe seen exactly 3 times.
- Memory stall: hold `mem_pronta`=0 for 4 cycles in phase 6. Required: `fase` stays 6, `en_mem` high for 5 cycles, instruction takes 14 cycles, `en_escrita` arrives 2 cycles after `mem_pronta` rises.
- Halt: pulse `parar` in phase 2 of instruction 2. Required:
  - instruction 2 completes and `num_instr`=2;
  - PARADO with `ocupado`=0 and `fase`=0;
  - a later `iniciar` resumes with `num_instr` continuing from 2.
- Async reset mid-stall: drive `reset`=0 between clock edges during ESPERA_MEM. Required: `ocupado`, `en_mem` and `num_instr` go to 0 before the next edge, with state OCIOSO.
- Ignored inputs: `iniciar` pulsed in phase 3, and `mem_pronta` toggled in phases 0-5. Required: no change to `fase` progression or cycle count.
